// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared opcodes, states and constants
// for the memory-access pipeline stage.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LH   = 4'd2,
    MOP_LW   = 4'd3,
    MOP_LBU  = 4'd4,
    MOP_LHU  = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } state_e;

  localparam logic [31:0] ZERO_WORD    = 32'h0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        ResetEnable  = 1'b1;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       is_signed;
    logic [2:0] nbytes;
  } op_info_t;

  // Unknown opcodes decode to all-zero, i.e. behave as NONE.
  function automatic op_info_t decode_op(
    input logic [3:0] op
  );
    op_info_t r;
    r = '0;
    case (op)
      MOP_LB:  r = '{1'b1, 1'b0, 1'b1, 3'd1};
      MOP_LH:  r = '{1'b1, 1'b0, 1'b1, 3'd2};
      MOP_LW:  r = '{1'b1, 1'b0, 1'b0, 3'd4};
      MOP_LBU: r = '{1'b1, 1'b0, 1'b0, 3'd1};
      MOP_LHU: r = '{1'b1, 1'b0, 1'b0, 3'd2};
      MOP_SB:  r = '{1'b0, 1'b1, 1'b0, 3'd1};
      MOP_SH:  r = '{1'b0, 1'b1, 1'b0, 3'd2};
      MOP_SW:  r = '{1'b0, 1'b1, 1'b0, 3'd4};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: upstream, write-back and RAM
// signals of the memory-access stage.
interface mem_stage_if #(
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 32,
  parameter int RADDR_W = 5
) ();

  logic               valid_i;
  logic [3:0]         mem_op_i;
  logic [REG_W-1:0]   rd_data_i;
  logic [RADDR_W-1:0] rd_addr_i;
  logic               rd_enable_i;
  logic [ADDR_W-1:0]  mem_addr_i;
  logic [REG_W-1:0]   store_data_i;

  logic               stall_req;
  logic               valid_o;
  logic [REG_W-1:0]   rd_data_o;
  logic [RADDR_W-1:0] rd_addr_o;
  logic               rd_enable_o;

  logic [ADDR_W-1:0]  ram_a;
  logic [7:0]         ram_dout;
  logic               ram_wr;
  logic [7:0]         ram_din;

  modport master (
    output valid_i, mem_op_i, rd_data_i,
    output rd_addr_i, rd_enable_i,
    output mem_addr_i, store_data_i,
    output ram_din,
    input  stall_req, valid_o, rd_data_o,
    input  rd_addr_o, rd_enable_o,
    input  ram_a, ram_dout, ram_wr
  );

  modport slave (
    input  valid_i, mem_op_i, rd_data_i,
    input  rd_addr_i, rd_enable_i,
    input  mem_addr_i, store_data_i,
    input  ram_din,
    output stall_req, valid_o, rd_data_o,
    output rd_addr_o, rd_enable_o,
    output ram_a, ram_dout, ram_wr
  );

endinterface

// File: rtl/mem_stage_load_extend.sv
// mem_stage_load_extend: trims assembled load
// bytes to N and sign- or zero-extends.
module mem_stage_load_extend #(
  parameter int REG_W = 32
) (
  input  logic [REG_W-1:0] i_bytes,
  input  logic [2:0]       i_nbytes,
  input  logic             i_signed,
  output logic [REG_W-1:0] o_result
);

  logic w_sign;

  // Pick the top bit of the loaded width.
  always_comb begin
    w_sign = 1'b0;
    unique case (1'b1)
      (i_nbytes == 3'd1): w_sign = i_bytes[7];
      (i_nbytes == 3'd2): w_sign = i_bytes[15];
      (i_nbytes == 3'd4): w_sign = i_bytes[31];
      default:            w_sign = 1'b0;
    endcase
  end

  // Keep loaded bits, fill the rest.
  always_comb begin
    o_result = '0;
    for (int i = 0; i < REG_W; i++) begin
      if (i < 8 * int'(i_nbytes))
        o_result[i] = i_bytes[i];
      else
        o_result[i] = i_signed & w_sign;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: byte-serial load/store stage
// over an 8-bit synchronous RAM port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int REG_W   = 32,
  parameter int RADDR_W = 5
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);

  state_e             r_state;
  state_e             w_next;
  logic [2:0]         r_cnt;
  logic [2:0]         r_n;
  logic               r_signed;
  logic [RADDR_W-1:0] r_rd_addr;
  logic               r_rd_en;
  logic [REG_W-1:0]   r_sdata;
  logic [REG_W-1:0]   r_bytes;

  logic               r_valid;
  logic [REG_W-1:0]   r_rd_data;
  logic [RADDR_W-1:0] r_rd_addr_o;
  logic               r_rd_en_o;
  logic [ADDR_W-1:0]  r_ram_a;
  logic [7:0]         r_ram_dout;
  logic               r_ram_wr;

  op_info_t           w_op;
  logic               w_accept;
  logic               w_none_done;
  logic               w_load_done;
  logic               w_store_done;
  logic               w_stall;
  logic [REG_W-1:0]   w_asm;
  logic [REG_W-1:0]   w_ext;

  assign w_op = decode_op(bus.mem_op_i);

  // State register.
  always_ff @(posedge clk) begin
    if (rst == ResetEnable)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Next state: start on accept, finish on last byte.
  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (w_accept && w_op.is_load):   w_next = ST_LOAD;
      (w_accept && w_op.is_store):  w_next = ST_STORE;
      (w_load_done || w_store_done): w_next = ST_IDLE;
      default: ;
    endcase
  end

  // Per-state control strobes and stall.
  always_comb begin
    w_accept     = 1'b0;
    w_none_done  = 1'b0;
    w_load_done  = 1'b0;
    w_store_done = 1'b0;
    w_stall      = 1'b0;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        w_accept    = bus.valid_i;
        w_none_done = bus.valid_i
                    & ~w_op.is_load
                    & ~w_op.is_store;
      end
      (r_state == ST_LOAD): begin
        w_stall     = 1'b1;
        w_load_done = (r_cnt == r_n);
      end
      (r_state == ST_STORE): begin
        w_stall      = 1'b1;
        w_store_done = (r_cnt == r_n - 3'd1);
      end
      default: ;
    endcase
  end

  // Merge the byte arriving this cycle into the word.
  always_comb begin
    w_asm = r_bytes;
    if (r_state == ST_LOAD && r_cnt != 3'd0)
      w_asm[{r_cnt - 3'd1, 3'b000} +: 8] = bus.ram_din;
  end

  mem_stage_load_extend #(
    .REG_W (REG_W)
  ) u_load_extend (
    .i_bytes  (w_asm),
    .i_nbytes (r_n),
    .i_signed (r_signed),
    .o_result (w_ext)
  );

  // Datapath: latch on accept, step bytes, publish result.
  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      r_cnt       <= '0;
      r_n         <= '0;
      r_signed    <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_en     <= 1'b0;
      r_sdata     <= '0;
      r_bytes     <= '0;
      r_valid     <= 1'b0;
      r_rd_data   <= '0;
      r_rd_addr_o <= '0;
      r_rd_en_o   <= 1'b0;
      r_ram_a     <= '0;
      r_ram_dout  <= '0;
      r_ram_wr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_cnt     <= '0;
        r_n       <= w_op.nbytes;
        r_signed  <= w_op.is_signed;
        r_rd_addr <= bus.rd_addr_i;
        r_rd_en   <= bus.rd_enable_i;
        r_bytes   <= '0;
        if (w_none_done) begin
          r_valid     <= 1'b1;
          r_rd_data   <= bus.rd_data_i;
          r_rd_addr_o <= bus.rd_addr_i;
          r_rd_en_o   <= bus.rd_enable_i;
        end else begin
          r_ram_a    <= bus.mem_addr_i;
          r_ram_dout <= bus.store_data_i[7:0];
          r_sdata    <= bus.store_data_i >> 8;
          r_ram_wr   <= w_op.is_store ? WriteEnable
                                      : WriteDisable;
        end
      end else if (w_load_done) begin
        r_valid     <= 1'b1;
        r_rd_data   <= w_ext;
        r_rd_addr_o <= r_rd_addr;
        r_rd_en_o   <= r_rd_en;
      end else if (w_store_done) begin
        r_valid     <= 1'b1;
        r_rd_data   <= REG_W'(ZERO_WORD);
        r_rd_addr_o <= r_rd_addr;
        r_rd_en_o   <= WriteDisable;
        r_ram_wr    <= WriteDisable;
      end else if (r_state == ST_LOAD) begin
        r_bytes <= w_asm;
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt < r_n - 3'd1)
          r_ram_a <= r_ram_a + ADDR_W'(1);
      end else if (r_state == ST_STORE) begin
        r_cnt      <= r_cnt + 3'd1;
        r_ram_a    <= r_ram_a + ADDR_W'(1);
        r_ram_dout <= r_sdata[7:0];
        r_sdata    <= r_sdata >> 8;
      end
    end
  end

  assign bus.stall_req   = w_stall;
  assign bus.valid_o     = r_valid;
  assign bus.rd_data_o   = r_rd_data;
  assign bus.rd_addr_o   = r_rd_addr_o;
  assign bus.rd_enable_o = r_rd_en_o;
  assign bus.ram_a       = r_ram_a;
  assign bus.ram_dout    = r_ram_dout;
  assign bus.ram_wr      = r_ram_wr;

endmodule
